// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes, also used by the free list and the ROB.
package rename_pkg;

  localparam int unsigned NUM_AR = 32;
  localparam int unsigned NUM_PR = 64;
  localparam int unsigned AR_W   = 5;
  localparam int unsigned PR_W   = 6;

  typedef logic [AR_W-1:0] ar_t;
  typedef logic [PR_W-1:0] pr_t;

  // Source selected for the single map-table write port.
  typedef enum logic [1:0] {
    MapWrNone    = 2'd0,
    MapWrRename  = 2'd1,
    MapWrRecover = 2'd2
  } map_wr_src_e;

  typedef struct packed {
    logic en;
    ar_t  idx;
    pr_t  pr;
  } map_wr_t;

  // Identity mapping loaded at reset: arch reg i lives in PR i.
  function automatic pr_t reset_map_entry(input int unsigned ar);
    return pr_t'(ar);
  endfunction

endpackage

// File: rtl/pr_ready_table.sv
// Per-PR ready scoreboard: set by CDB writeback, cleared on rename allocation.
// Two lookup ports see a same-cycle CDB hit through a bypass.
module pr_ready_table
  import rename_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set_en_i,
  input  pr_t  set_pr_i,
  input  logic clr_en_i,
  input  pr_t  clr_pr_i,
  input  pr_t  lk0_pr_i,
  input  pr_t  lk1_pr_i,
  output logic lk0_ready_o,
  output logic lk1_ready_o
);

  logic [NUM_PR-1:0] ready_q, ready_d;

  // Next state: set applied first so a same-edge clear of the same PR wins.
  always_comb begin
    ready_d = ready_q;
    if (set_en_i) ready_d[set_pr_i] = 1'b1;
    if (clr_en_i) ready_d[clr_pr_i] = 1'b0;
  end

  // Ready vector; every PR holds a valid value out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= '1;
    else     ready_q <= ready_d;
  end

  assign lk0_ready_o = ready_q[lk0_pr_i] | (set_en_i & (set_pr_i == lk0_pr_i));
  assign lk1_ready_o = ready_q[lk1_pr_i] | (set_en_i & (set_pr_i == lk1_pr_i));

endmodule

// File: rtl/rename_map_table.sv
// Register alias table for the rename stage. Supplies source PRs with ready
// bits and the displaced dest PR; restored by the ROB rollback walk.
module rename_map_table
  import rename_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AR_W-1:0] rs_arch,
  input  logic [AR_W-1:0] rt_arch,
  input  logic [AR_W-1:0] rd_arch,
  input  logic            RegDest,
  input  logic [PR_W-1:0] PR_new,
  input  logic            free_empty,
  input  logic            hazard_stall,
  input  logic            stall_recover,
  input  logic            recover,
  input  logic [AR_W-1:0] rec_arch,
  input  logic [PR_W-1:0] rec_PR_old,
  input  logic            rec_RegDest,
  input  logic            cdb_valid,
  input  logic [PR_W-1:0] cdb_PR,
  output logic [PR_W-1:0] PR_rs,
  output logic [PR_W-1:0] PR_rt,
  output logic [PR_W-1:0] PR_old,
  output logic            rs_ready,
  output logic            rt_ready,
  output logic            rename_fire
);

  pr_t         map_q [NUM_AR];
  pr_t         map_d [NUM_AR];
  map_wr_src_e wr_src;
  map_wr_t     map_wr;
  logic        rec_wr;

  // Must match the free-list read condition exactly; recover excludes rename.
  assign rename_fire = RegDest & ~free_empty & ~hazard_stall & ~stall_recover & ~recover;
  assign rec_wr      = recover & rec_RegDest & ~hazard_stall;

  // Reads reflect pre-edge state, so rd==rs still returns the old mapping.
  assign PR_rs  = map_q[rs_arch];
  assign PR_rt  = map_q[rt_arch];
  assign PR_old = map_q[rd_arch];

  // Write-port arbitration between rename and rollback restore.
  always_comb begin
    wr_src = MapWrNone;
    if (rename_fire) wr_src = MapWrRename;
    else if (rec_wr) wr_src = MapWrRecover;
  end

  // Write-port mux.
  always_comb begin
    map_wr = '0;
    unique case (wr_src)
      MapWrRename: begin
        map_wr.en  = 1'b1;
        map_wr.idx = rd_arch;
        map_wr.pr  = PR_new;
      end
      MapWrRecover: begin
        map_wr.en  = 1'b1;
        map_wr.idx = rec_arch;
        map_wr.pr  = rec_PR_old;
      end
      default: map_wr = '0;
    endcase
  end

  // Map next state: single write, youngest-first walk lets the oldest PR_old win.
  always_comb begin
    map_d = map_q;
    if (map_wr.en) map_d[map_wr.idx] = map_wr.pr;
  end

  // Map flop array; identity mapping on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AR; i++) map_q[i] <= reset_map_entry(i);
    end else begin
      map_q <= map_d;
    end
  end

  pr_ready_table u_ready (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (cdb_valid),
    .set_pr_i   (cdb_PR),
    .clr_en_i   (rename_fire),
    .clr_pr_i   (PR_new),
    .lk0_pr_i   (PR_rs),
    .lk1_pr_i   (PR_rt),
    .lk0_ready_o(rs_ready),
    .lk1_ready_o(rt_ready)
  );

  // A PR leaving the free list cannot have a producer in flight.
  cdb_to_alloc_pr: assert property (@(posedge clk) disable iff (rst)
      !(cdb_valid && rename_fire && (cdb_PR == PR_new)))
    else $warning("cdb writeback to PR %0d while it is being allocated", PR_new);

endmodule
